// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back controller and busy-bit scoreboard for the
// 32x32 integer register file.
//
// The block arbitrates two result producers onto the single register-file
// write port. Port A is the single-cycle ALU and port B is the multi-cycle
// LSU/MUL. It also tracks per-register busy bits so that issue can stall on
// RAW/WAW hazards.
//
// Optional feature: define WB_RR_EN to get round-robin arbitration.
// Without it, A always beats B.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   alloc_valid/alloc_rd    issue marks a destination register busy
//   chk_rs1/rs2/rd_addr     issuing instruction's registers; stall (comb)
//   a_valid/a_ready/a_rd/a_data   ALU result handshake
//   b_valid/b_ready/b_rd/b_data   LSU/MUL result handshake
//   flush                   clears all busy bits
//   rf_we/rf_rd_addr/rf_rd_data   registered register-file write port
//   wb_err                  sticky: write-back to a register that was not busy
module regfile_wb_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  input  logic [4:0]        chk_rs1_addr,
  input  logic [4:0]        chk_rs2_addr,
  input  logic [4:0]        chk_rd_addr,
  output logic              stall,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_rd,
  input  logic [XLEN-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_rd,
  input  logic [XLEN-1:0]   b_data,
  input  logic              flush,
  output logic              rf_we,
  output logic [4:0]        rf_rd_addr,
  output logic [XLEN-1:0]   rf_rd_data,
  output logic              wb_err
);

  localparam int unsigned NREG   = 32;
  localparam int unsigned ADDR_W = 5;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
  logic [XLEN-1:0]   rf_rd_data_q, rf_rd_data_d;
  logic              wb_err_q, wb_err_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              a_gnt, b_gnt, win;
  logic [ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]   win_data;

`ifdef WB_RR_EN
  typedef enum logic {FAV_A = 1'b0, FAV_B = 1'b1} rr_e;
  rr_e rr_q, rr_d;
`endif

  // Arbitration: a single requester always wins; a conflict is resolved by
  // policy. Nothing is granted while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
`ifdef WB_RR_EN
    rr_d  = rr_q;
`endif
    if (rst_n) begin
      if (a_valid && b_valid) begin
`ifdef WB_RR_EN
        if (rr_q == FAV_A) a_gnt = 1'b1;
        else               b_gnt = 1'b1;
        // The loser is favoured on the next conflict
        rr_d = (rr_q == FAV_A) ? FAV_B : FAV_A;
`else
        a_gnt = 1'b1;
`endif
      end else begin
        a_gnt = a_valid;
        b_gnt = b_valid;
      end
    end
  end

  assign win      = a_gnt | b_gnt;
  assign win_rd   = a_gnt ? a_rd   : b_rd;
  assign win_data = a_gnt ? a_data : b_data;

  // Write port, error flag and scoreboard next state
  always_comb begin
    rf_we_d      = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_rd_data_d = rf_rd_data_q;
    wb_err_d     = wb_err_q;
    busy_d       = busy_q;

    if (win) begin
      // A write to x0 is accepted and then dropped
      rf_we_d      = (win_rd != ADDR_W'(0));
      rf_rd_addr_d = win_rd;
      rf_rd_data_d = win_data;
      if ((win_rd != ADDR_W'(0)) && !busy_q[win_rd]) wb_err_d = 1'b1;
    end

    // A clear and a set of the same register on one edge: the set wins
    if (rf_we_q) busy_d[rf_rd_addr_q] = 1'b0;
    if (alloc_valid && (alloc_rd != ADDR_W'(0))) busy_d[alloc_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_rd_data_q <= '0;
      wb_err_q     <= 1'b0;
      busy_q       <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_rd_data_q <= rf_rd_data_d;
      wb_err_q     <= wb_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef WB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= FAV_A;
    else        rr_q <= rr_d;
  end
`endif

  assign stall      = busy_q[chk_rs1_addr] | busy_q[chk_rs2_addr] | busy_q[chk_rd_addr];
  assign a_ready    = a_gnt;
  assign b_ready    = b_gnt;
  assign rf_we      = rf_we_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_rd_data = rf_rd_data_q;
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl. Expected values are
// hand-derived; round-robin expectations apply when WB_RR_EN is defined.
module tb_regfile_wb_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alloc_valid;
  logic [4:0]      alloc_rd;
  logic [4:0]      chk_rs1_addr, chk_rs2_addr, chk_rd_addr;
  logic            stall;
  logic            a_valid, a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid, b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            flush;
  logic            rf_we;
  logic [4:0]      rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic            wb_err;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .chk_rs1_addr (chk_rs1_addr),
    .chk_rs2_addr (chk_rs2_addr),
    .chk_rd_addr  (chk_rd_addr),
    .stall        (stall),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_a;
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
    chk_rs1_addr = '0; chk_rs2_addr = '0; chk_rd_addr = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    flush = 1'b0;

    // Reset state; the readies stay low in reset even with valids up
    a_valid = 1'b1; b_valid = 1'b1;
    #12;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_rf_we",   32'(rf_we), 32'd0);
    check("rst_addr",    32'(rf_rd_addr), 32'd0);
    check("rst_data",    rf_rd_data, 32'd0);
    check("rst_wb_err",  32'(wb_err), 32'd0);
    check("rst_stall",   32'(stall), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    #5 rst_n = 1'b1;
    tick();

    // Basic write-back to x5 and the stall window
    alloc_valid = 1'b1; alloc_rd = 5'd5;
    tick();
    alloc_valid = 1'b0; chk_rs1_addr = 5'd5;
    #1 check("t1_stall_busy", 32'(stall), 32'd1);
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    #1 check("t1_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    check("t1_rf_we",   32'(rf_we), 32'd1);
    check("t1_addr",    32'(rf_rd_addr), 32'd5);
    check("t1_data",    rf_rd_data, 32'h1234);
    check("t1_stall_wr", 32'(stall), 32'd1);
    tick();
    check("t1_rf_we_off", 32'(rf_we), 32'd0);
    check("t1_stall_clr", 32'(stall), 32'd0);
    check("t1_data_hold", rf_rd_data, 32'h1234);
    check("t1_wb_err",  32'(wb_err), 32'd0);
    chk_rs1_addr = '0;

    // Simultaneous A(rd=3) and B(rd=4)
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_rd = 5'd4;
    tick();
    alloc_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
    #1 check("t2_c1_a_ready", 32'(a_ready), 32'd1);
    check("t2_c1_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("t2_c1_addr", 32'(rf_rd_addr), 32'd3);
`ifndef WB_RR_EN
    a_valid = 1'b0;
`endif
    #1 check("t2_c2_a_ready", 32'(a_ready), 32'd0);
    check("t2_c2_b_ready", 32'(b_ready), 32'd1);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("t2_c2_we",   32'(rf_we), 32'd1);
    check("t2_c2_addr", 32'(rf_rd_addr), 32'd4);
    check("t2_c2_data", rf_rd_data, 32'h44);
    tick();
    chk_rs1_addr = 5'd3; chk_rs2_addr = 5'd4;
    #1 check("t2_stall_clr", 32'(stall), 32'd0);
    check("t2_wb_err", 32'(wb_err), 32'd0);
    chk_rs1_addr = '0; chk_rs2_addr = '0;

    // Continuous A and B for 6 cycles (rd=0, so no writes and no errors)
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hA;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hB;
    for (int i = 0; i < 6; i++) begin
`ifdef WB_RR_EN
      exp_a = ((i % 2) == 0);
`else
      exp_a = 1'b1;
`endif
      #1;
      check($sformatf("t3_a_ready_%0d", i), 32'(a_ready), 32'(exp_a));
      check($sformatf("t3_b_ready_%0d", i), 32'(b_ready), 32'(!exp_a));
      tick();
      check($sformatf("t3_data_%0d", i), rf_rd_data, exp_a ? 32'hA : 32'hB);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("t3_wb_err", 32'(wb_err), 32'd0);

    // Write to x0 is accepted and dropped
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    #1 check("t4_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    check("t4_rf_we", 32'(rf_we), 32'd0);
    check("t4_wb_err", 32'(wb_err), 32'd0);

    // Set beats clear on the same edge, then flush beats set
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    tick();
    a_valid = 1'b0;
    check("t5_we", 32'(rf_we), 32'd1);
    check("t5_addr", 32'(rf_rd_addr), 32'd7);
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 1'b0; chk_rd_addr = 5'd7;
    #1 check("t5_set_wins", 32'(stall), 32'd1);
    flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd8;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    chk_rs1_addr = 5'd8;
    #1 check("t5_flush_stall", 32'(stall), 32'd0);
    check("t5_wb_err", 32'(wb_err), 32'd0);
    chk_rs1_addr = '0; chk_rd_addr = '0;

    // Write-back to non-busy x9 raises the sticky error
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    tick();
    check("t6_we", 32'(rf_we), 32'd1);
    check("t6_data", rf_rd_data, 32'h99);
    check("t6_wb_err", 32'(wb_err), 32'd1);
    a_data = 32'h9A;
    tick();
    a_valid = 1'b0;
    check("t6_we2", 32'(rf_we), 32'd1);
    check("t6_wb_err_hold", 32'(wb_err), 32'd1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    #1 rst_n = 1'b0;
    #1;
    check("t6_arst_wb_err", 32'(wb_err), 32'd0);
    check("t6_arst_rf_we",  32'(rf_we), 32'd0);
    check("t6_arst_data",   rf_rd_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
